// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and constants for the data-memory access unit
package mem_pkg;
    localparam int WORD_W        = 32;
    localparam int MEM_WORDS_DEF = 65536;
    typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;
endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: load return stage, tracks the memory's registered read and captures the word
module mem_rd_pipe
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue,
    input  logic              i_last,
    input  logic [WORD_W-1:0] i_rdata,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic              o_last
);
    logic              r_pend;
    logic              r_pend_last;
    logic              r_valid;
    logic              r_last;
    logic [WORD_W-1:0] r_data;

    // first stage waits out the memory latency, second stage captures the returned word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_pend      <= i_issue;
            r_pend_last <= i_issue & i_last;
            r_valid     <= r_pend;
            r_last      <= r_pend_last;
            if (r_pend)
                r_data <= i_rdata;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-master burst load/store initiator for the data memory port
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int LEN_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);
    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_err;
    logic [32:0]       w_end;
    logic              w_oor;
    logic              w_hs;
    logic              w_last_issue;

    assign w_end        = {1'b0, cmd_addr} + 33'(cmd_len) + 33'd1;
    assign w_oor        = w_end > 33'(MEM_WORDS);
    assign w_hs         = (r_state == WR) & wr_valid;
    assign w_last_issue = r_rem == '0;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next-state: reads stream without bubbles, writes advance only on handshake
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (cmd_valid) w_next = w_oor ? DONE : (cmd_write ? WR : RD);
            RD:      if (r_rem == '0) w_next = RD_TAIL;
            RD_TAIL: w_next = DONE;
            WR:      if (w_hs && r_rem == '0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // port decode straight from state so strobes drop the moment reset asserts
    always_comb begin
        cmd_ready = r_state == IDLE;
        busy      = r_state != IDLE;
        mem_read  = r_state == RD;
        wr_ready  = r_state == WR;
        mem_write = wr_ready & wr_valid;
        mem_addr  = (mem_read | wr_ready) ? r_addr : '0;
        mem_wdata = wr_ready ? wr_data : '0;
        done      = r_state == DONE;
        err       = done & r_err;
    end

    // command latch and per-word address/remaining-count advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_err  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (cmd_valid) begin
                r_addr <= cmd_addr;
                r_rem  <= cmd_len;
                r_err  <= w_oor;
            end
        end else if (mem_read | w_hs) begin
            r_addr <= r_addr + 32'd1;
            if (r_rem != '0)
                r_rem <= r_rem - 1'b1;
        end
    end

    mem_rd_pipe u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_issue (mem_read),
        .i_last  (w_last_issue),
        .i_rdata (mem_rdata),
        .o_valid (rd_valid),
        .o_data  (rd_data),
        .o_last  (rd_last)
    );
endmodule
